// File: rtl/byte_decode.sv
// Unpacks 32*D bytes into 256 D-bit coefficients (ByteDecode_D bit order); BYTE_DECODE_MOD_Q_EN adds mod-3329 reduction for D=12.
// Latency 1 cycle, one polynomial per clock; no backpressure, valid_i accepted every cycle.
module byte_decode #(
  parameter int D = 12,
  localparam int OUT_WIDTH = D
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  input  logic [32*D-1:0][7:0]        b_i,
  output logic                        valid_o,
  output logic [255:0][OUT_WIDTH-1:0] f_o
);

  if (D < 1 || D > 12) begin : g_bad_d
    $error("byte_decode: D must be in 1..12");
  end

  logic [256*D-1:0]            stream;
  logic [255:0][OUT_WIDTH-1:0] dec;

  // Byte k occupies stream bits 8k..8k+7, so the packed array is already the bitstream.
  assign stream = b_i;

  for (genvar i = 0; i < 256; i++) begin : g_coef
    logic [D-1:0] raw;
    assign raw = stream[i*D +: D];
`ifdef BYTE_DECODE_MOD_Q_EN
    if (D == 12) begin : g_modq
      // Raw values never exceed 4095 < 2q, so one conditional subtract suffices.
      assign dec[i] = (raw >= 12'd3329) ? raw - 12'd3329 : raw;
    end else begin : g_raw
      assign dec[i] = raw;
    end
`else
    assign dec[i] = raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      f_o     <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        f_o <= dec;
      end
    end
  end

endmodule

// File: tb/tb_byte_decode.sv
// Directed bench for byte_decode: six instances (D=1,4,8,10,11,12) share clock, reset and valid.
module tb_byte_decode;

`ifdef BYTE_DECODE_MOD_Q_EN
  localparam bit MODQ = 1'b1;
`else
  localparam bit MODQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic valid_i;

  logic [31:0][7:0]   b1;
  logic [127:0][7:0]  b4;
  logic [255:0][7:0]  b8;
  logic [319:0][7:0]  b10;
  logic [351:0][7:0]  b11;
  logic [383:0][7:0]  b12;
  logic [255:0][0:0]  f1;
  logic [255:0][3:0]  f4;
  logic [255:0][7:0]  f8;
  logic [255:0][9:0]  f10;
  logic [255:0][10:0] f11;
  logic [255:0][11:0] f12;
  logic v1, v4, v8, v10, v11, v12;

  int n_cmp = 0;
  int n_bad = 0;
  int dl [6] = '{1, 4, 8, 10, 11, 12};
  logic [3071:0] ex [6];
  logic [11:0]   cur [256];
  logic [3071:0] s;

  always #5 clk = ~clk;

  byte_decode #(.D(1))  u_d1  (.clk(clk), .rst_n(rst_n), .valid_i(valid_i), .b_i(b1),  .valid_o(v1),  .f_o(f1));
  byte_decode #(.D(4))  u_d4  (.clk(clk), .rst_n(rst_n), .valid_i(valid_i), .b_i(b4),  .valid_o(v4),  .f_o(f4));
  byte_decode #(.D(8))  u_d8  (.clk(clk), .rst_n(rst_n), .valid_i(valid_i), .b_i(b8),  .valid_o(v8),  .f_o(f8));
  byte_decode #(.D(10)) u_d10 (.clk(clk), .rst_n(rst_n), .valid_i(valid_i), .b_i(b10), .valid_o(v10), .f_o(f10));
  byte_decode #(.D(11)) u_d11 (.clk(clk), .rst_n(rst_n), .valid_i(valid_i), .b_i(b11), .valid_o(v11), .f_o(f11));
  byte_decode #(.D(12)) u_d12 (.clk(clk), .rst_n(rst_n), .valid_i(valid_i), .b_i(b12), .valid_o(v12), .f_o(f12));

  // Reference encoder: coefficient bit j lands at stream bit i*d+j.
  function automatic logic [3071:0] enc(int d, logic [11:0] c [256]);
    logic [3071:0] r = '0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < d; j++)
        r[i*d+j] = c[i][j];
    return r;
  endfunction

  function automatic logic [3071:0] exp_of(int d, logic [11:0] c [256]);
    logic [11:0] t [256];
    for (int i = 0; i < 256; i++) begin
      t[i] = c[i];
      if (d == 12 && MODQ && t[i] >= 12'd3329) t[i] = t[i] - 12'd3329;
    end
    return enc(d, t);
  endfunction

  function automatic logic [3071:0] flat(int d);
    logic [3071:0] g = '0;
    case (d)
      1:       g[255:0]  = f1;
      4:       g[1023:0] = f4;
      8:       g[2047:0] = f8;
      10:      g[2559:0] = f10;
      11:      g[2815:0] = f11;
      default: g         = f12;
    endcase
    return g;
  endfunction

  task automatic set_b(int d, logic [3071:0] v);
    case (d)
      1:       b1  = v[255:0];
      4:       b4  = v[1023:0];
      8:       b8  = v[2047:0];
      10:      b10 = v[2559:0];
      11:      b11 = v[2815:0];
      default: b12 = v;
    endcase
  endtask

  task automatic load(logic [11:0] c [256]);
    for (int n = 0; n < 6; n++) begin
      set_b(dl[n], enc(dl[n], c));
      ex[n] = exp_of(dl[n], c);
    end
  endtask

  task automatic rand_cur();
    for (int i = 0; i < 256; i++) cur[i] = 12'($urandom_range(0, 4095));
  endtask

  task automatic chk_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic chk_vec(string tag, int d, logic [3071:0] exp);
    logic [3071:0] got = flat(d);
    logic [3071:0] m   = (3072'd1 << d) - 3072'd1;
    int k = 0;
    for (int i = 255; i >= 0; i--)
      if (((got >> (i*d)) & m) !== ((exp >> (i*d)) & m)) k = i;
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s D=%0d: coef %0d got %0d, expected %0d", tag, d, k,
             12'((got >> (k*d)) & m), 12'((exp >> (k*d)) & m));
    end
  endtask

  task automatic check_all(string tag, logic exp_v);
    chk_val({tag, "_valid"}, {26'd0, v1, v4, v8, v10, v11, v12}, exp_v ? 32'h3f : 32'h0);
    for (int n = 0; n < 6; n++) chk_vec(tag, dl[n], ex[n]);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    for (int n = 0; n < 6; n++) begin
      set_b(dl[n], '0);
      ex[n] = '0;
    end

    // Reset state
    @(negedge clk);
    check_all("reset", 1'b0);

    // Directed patterns, valid on the first edge after release
    rst_n   = 1'b1;
    valid_i = 1'b1;
    s = '0; s[255:0] = {32{8'hAA}};
    set_b(1, s); ex[0] = s;
    set_b(4, '0);  ex[1] = '0;
    set_b(10, '0); ex[3] = '0;
    set_b(11, '0); ex[4] = '0;
    s = '0;
    for (int k = 0; k < 256; k++) s[k*8 +: 8] = 8'(k);
    set_b(8, s); ex[2] = s;
    s = '0;
    for (int i = 0; i < 256; i++) s[i*12 +: 12] = 12'(i);
    ex[5] = s;
    s[47:0] = 48'h003002001000;
    set_b(12, s);
    @(negedge clk);
    check_all("pattern", 1'b1);
    for (int i = 0; i < 4; i++) chk_val($sformatf("d12_c%0d", i), 32'(f12[i]), i);
    chk_val("d8_c200", 32'(f8[200]), 32'd200);
    chk_val("d1_c7", 32'(f1[7]), 32'd1);

    // All-ones input: 4095 raw, 766 after reduction
    for (int i = 0; i < 256; i++) cur[i] = 12'hFFF;
    s = '1;
    for (int n = 0; n < 6; n++) set_b(dl[n], s);
    for (int n = 0; n < 6; n++) ex[n] = exp_of(dl[n], cur);
    @(negedge clk);
    check_all("ones", 1'b1);
    chk_val("d12_c0_ones",   32'(f12[0]),   MODQ ? 32'd766 : 32'd4095);
    chk_val("d12_c255_ones", 32'(f12[255]), MODQ ? 32'd766 : 32'd4095);
    chk_val("d10_c9_ones",   32'(f10[9]),   32'd1023);

    // valid_i low: valid_o drops, f_o holds
    valid_i = 1'b0;
    rand_cur();
    for (int n = 0; n < 6; n++) set_b(dl[n], enc(dl[n], cur));
    @(negedge clk);
    check_all("hold", 1'b0);

    // Reset asserted between edges while output is valid and input is in flight
    valid_i = 1'b1;
    rand_cur();
    load(cur);
    @(negedge clk);
    check_all("pre_reset", 1'b1);
    rand_cur();
    load(cur);
    #2 rst_n = 1'b0;
    #1;
    for (int n = 0; n < 6; n++) ex[n] = '0;
    check_all("async_reset", 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    check_all("no_stale", 1'b0);

    // Back-to-back round trip through the reference encoder
    valid_i = 1'b1;
    rand_cur();
    load(cur);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check_all($sformatf("rt%0d", k - 1), 1'b1);
      if (k < 24) begin
        rand_cur();
        load(cur);
      end
    end
    valid_i = 1'b0;
    @(negedge clk);
    chk_val("final_valid", {26'd0, v1, v4, v8, v10, v11, v12}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
